regfile_wb_scheduler: RTL and testbench
=======================================

Name: regfile_wb_scheduler

Overview:
Owns the single write port (enc/addrc/datac) of the 32x32 register bank. Arbitrates it between the ALU and load writeback sources using round-robin. Also keeps a per-register pending scoreboard, and stalls the issue stage on RAW and WAW hazards against writebacks that have not yet committed. Sits between decode/issue, the EX/MEM writeback paths and the register bank.

Parameters:
NUM_REGS, 32, number of architectural registers
ADDR_W, 5, register address width
DATA_W, 32, register data width

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
alu_valid  in  1  ALU writeback request
alu_ready  out  1  ALU request granted this cycle
alu_addr  in  ADDR_W  ALU destination register
alu_data  in  DATA_W  ALU result
mem_valid  in  1  load writeback request
mem_ready  out  1  load request granted this cycle
mem_addr  in  ADDR_W  load destination register
mem_data  in  DATA_W  load data
enc  out  1  register bank write enable (registered)
addrc  out  ADDR_W  register bank write address (registered)
datac  out  DATA_W  register bank write data (registered)
iss_valid  in  1  instruction presented for issue
iss_rs  in  ADDR_W  source register A
iss_rt  in  ADDR_W  source register B
iss_rd  in  ADDR_W  destination register
iss_we  in  1  instruction writes iss_rd
stall  out  1  issue blocked (combinational)
pending  out  NUM_REGS  scoreboard bits (debug/visibility)

Behaviour:
- Reset (synchronous, high): enc=0, addrc=0, datac=0, pending=0, RR pointer favours ALU. alu_ready=mem_ready=0 while reset is high.
- Handshake: a source holds valid/addr/data stable until ready. Transfer = valid & ready. ready is combinational from the valids and the RR pointer. At most one ready per cycle.
- Arbitration:
  - Only one source valid: that source is granted.
  - Both valid: the pointer source is granted, and the pointer flips to the other source.
  - Pointer is unchanged on uncontended grants.
- Write latency: a transfer in cycle N gives enc=1 with addrc/datac equal to the transfer addr/data in cycle N+1. With no transfer in cycle N, enc=0 in N+1 and addrc/datac hold their previous values.
- Register 0:
  - A transfer with addr 0 completes the handshake, but enc stays 0 in N+1.
  - pending[0] is always 0.
- Stall:
  - stall = iss_valid & ((rs!=0 & pending[rs]) | (rt!=0 & pending[rt]) | (iss_we & rd!=0 & pending[rd])).
  - iss_valid=0 gives stall=0.
- Set: an issue is accepted when iss_valid & ~stall. If it is accepted and iss_we & rd!=0, pending[rd] is 1 from the next edge.
- Clear: pending[addrc] clears on the edge where enc=1, which is the same edge the bank captures datac. A dependent instruction un-stalls in the cycle after enc is high.
- Set and clear of the same register on the same edge: set wins. The WAW stall normally prevents this case.
- Writeback to a register that is not pending: the write is still performed, and pending is unchanged.
- Reset mid-operation: in-flight grants and pending bits are discarded. No enc is produced in the cycle after reset deasserts unless a new transfer occurs.
- No combinational path from iss_* to alu_ready/mem_ready, or from *_valid to stall.

Decomposition:
- Shared package regfile_pkg holds:
  - NUM_REGS, ADDR_W, DATA_W
  - ZERO_REG = 0
  - writeback source id enum {SRC_ALU, SRC_MEM}
- One sub-module, wb_rr_arbiter: a 2-way round-robin grant with a pointer register, reset to SRC_ALU. The scoreboard and write port register stay in the top module.

Test Plan:
- Reset: hold reset 3 cycles with alu_valid=mem_valid=1 -> alu_ready=mem_ready=0, enc=0, pending=0; after release, ALU is granted first.
- Single write: alu_valid=1, alu_addr=5, alu_data=0xDEADBEEF at cycle N -> alu_ready=1 in N; enc=1, addrc=5, datac=0xDEADBEEF in N+1; enc=0 in N+2.
- Contention: both valid continuously, alu_addr=1 (data 0x11), mem_addr=2 (data 0x22) -> grants ALU, MEM, ALU, MEM; enc=1 every cycle; addrc sequence 1,2,1,2.
- RAW hazard:
  - issue rd=7 with iss_we=1 -> pending[7]=1.
  - Next cycle, iss_rs=7 -> stall=1.
  - mem writeback to r7 at cycle M -> enc in M+1, pending[7]=0 and stall=0 in M+2.
- Register 0:
  - issue rd=0 with iss_we=1 -> pending stays 0.
  - alu_addr=0 transfer -> alu_ready=1, enc=0 next cycle.
- Mid-operation reset: with pending[3]=1 and mem_valid=1, pulse reset for 1 cycle -> pending=0, mem_ready=0 during reset, enc=0 in the following cycle.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared sizes, the hard-wired zero register and writeback source ids for the
// register bank write-port scheduler.
package regfile_pkg;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;

  localparam logic [ADDR_W-1:0] ZERO_REG = '0;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } wb_src_e;

endpackage

// File: rtl/wb_rr_arbiter.sv
// Two-way round-robin grant between the ALU and load writeback sources.
// The pointer only moves when both sources contend.
module wb_rr_arbiter
  import regfile_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic alu_valid,
  input  logic mem_valid,
  output logic alu_grant,
  output logic mem_grant
);

  wb_src_e ptr;

  always_comb begin
    alu_grant = ~reset & alu_valid & (~mem_valid | (ptr == SRC_ALU));
    mem_grant = ~reset & mem_valid & (~alu_valid | (ptr == SRC_MEM));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr <= SRC_ALU;
    end else if (alu_valid & mem_valid) begin
      ptr <= (ptr == SRC_ALU) ? SRC_MEM : SRC_ALU;
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Register bank write-port owner: arbitrates ALU/load writebacks onto a
// registered write port and tracks pending destinations to stall issue.
module regfile_wb_scheduler
  import regfile_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                alu_valid,
  output logic                alu_ready,
  input  logic [ADDR_W-1:0]   alu_addr,
  input  logic [DATA_W-1:0]   alu_data,
  input  logic                mem_valid,
  output logic                mem_ready,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_data,
  output logic                enc,
  output logic [ADDR_W-1:0]   addrc,
  output logic [DATA_W-1:0]   datac,
  input  logic                iss_valid,
  input  logic [ADDR_W-1:0]   iss_rs,
  input  logic [ADDR_W-1:0]   iss_rt,
  input  logic [ADDR_W-1:0]   iss_rd,
  input  logic                iss_we,
  output logic                stall,
  output logic [NUM_REGS-1:0] pending
);

  logic                alu_grant;
  logic                mem_grant;
  logic                xfer;
  logic [ADDR_W-1:0]   xfer_addr;
  logic [DATA_W-1:0]   xfer_data;
  logic                haz_rs;
  logic                haz_rt;
  logic                haz_rd;
  logic                issue_set;
  logic [NUM_REGS-1:0] pending_nxt;

  wb_rr_arbiter u_arb (
    .clock     (clock),
    .reset     (reset),
    .alu_valid (alu_valid),
    .mem_valid (mem_valid),
    .alu_grant (alu_grant),
    .mem_grant (mem_grant)
  );

  assign alu_ready = alu_grant;
  assign mem_ready = mem_grant;

  always_comb begin
    xfer      = alu_grant | mem_grant;
    xfer_addr = mem_grant ? mem_addr : alu_addr;
    xfer_data = mem_grant ? mem_data : alu_data;
  end

  // Hazards look only at the scoreboard, never at in-flight valids.
  always_comb begin
    haz_rs    = (iss_rs != ZERO_REG) & pending[iss_rs];
    haz_rt    = (iss_rt != ZERO_REG) & pending[iss_rt];
    haz_rd    = iss_we & (iss_rd != ZERO_REG) & pending[iss_rd];
    stall     = iss_valid & (haz_rs | haz_rt | haz_rd);
    issue_set = iss_valid & ~stall & iss_we & (iss_rd != ZERO_REG);
  end

  // Clear is applied before set so a same-edge set of the same register wins.
  always_comb begin
    pending_nxt = pending;
    if (enc) begin
      pending_nxt[addrc] = 1'b0;
    end
    if (issue_set) begin
      pending_nxt[iss_rd] = 1'b1;
    end
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      enc     <= 1'b0;
      addrc   <= '0;
      datac   <= '0;
      pending <= '0;
    end else begin
      enc     <= xfer & (xfer_addr != ZERO_REG);
      pending <= pending_nxt;
      if (xfer) begin
        addrc <= xfer_addr;
        datac <= xfer_data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Self-checking bench for regfile_wb_scheduler: directed scenarios plus a
// randomized run against a behavioural scoreboard/arbitration model.
module tb_regfile_wb_scheduler;

  logic        clock;
  logic        reset;
  logic        alu_valid, mem_valid;
  logic        alu_ready, mem_ready;
  logic [4:0]  alu_addr, mem_addr;
  logic [31:0] alu_data, mem_data;
  logic        enc;
  logic [4:0]  addrc;
  logic [31:0] datac;
  logic        iss_valid, iss_we;
  logic [4:0]  iss_rs, iss_rt, iss_rd;
  logic        stall;
  logic [31:0] pending;

  int checks = 0;
  int errors = 0;

  // behavioural model state
  bit          m_pend [32];
  bit          m_fav_mem;
  bit          m_enc;
  logic [4:0]  m_addrc;
  logic [31:0] m_datac;
  bit          last_ga, last_gm;

  regfile_wb_scheduler dut (
    .clock     (clock),
    .reset     (reset),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_addr  (alu_addr),
    .alu_data  (alu_data),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .enc       (enc),
    .addrc     (addrc),
    .datac     (datac),
    .iss_valid (iss_valid),
    .iss_rs    (iss_rs),
    .iss_rt    (iss_rt),
    .iss_rd    (iss_rd),
    .iss_we    (iss_we),
    .stall     (stall),
    .pending   (pending)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] model_pend_vec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_pend[i];
    return v;
  endfunction

  function automatic bit busy(input logic [4:0] r);
    return (r != 0) && m_pend[r];
  endfunction

  function automatic bit exp_stall();
    if (!iss_valid) return 1'b0;
    return busy(iss_rs) || busy(iss_rt) || (iss_we && busy(iss_rd));
  endfunction

  function automatic bit exp_alu_rdy();
    if (reset || !alu_valid) return 1'b0;
    if (!mem_valid) return 1'b1;
    return !m_fav_mem;
  endfunction

  function automatic bit exp_mem_rdy();
    if (reset || !mem_valid) return 1'b0;
    if (!alu_valid) return 1'b1;
    return m_fav_mem;
  endfunction

  // Advance one clock, updating the model from the inputs present at the edge.
  task automatic tick();
    bit ga, gm, acc;
    logic [4:0] a;
    ga  = exp_alu_rdy();
    gm  = exp_mem_rdy();
    acc = iss_valid && !exp_stall();
    @(posedge clock);
    if (reset) begin
      for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
      m_fav_mem = 1'b0;
      m_enc     = 1'b0;
      m_addrc   = '0;
      m_datac   = '0;
    end else begin
      if (m_enc) m_pend[m_addrc] = 1'b0;
      if (acc && iss_we && iss_rd != 0) m_pend[iss_rd] = 1'b1;
      if (alu_valid && mem_valid) m_fav_mem = !m_fav_mem;
      if (ga || gm) begin
        a       = ga ? alu_addr : mem_addr;
        m_enc   = (a != 0);
        m_addrc = a;
        m_datac = ga ? alu_data : mem_data;
      end else begin
        m_enc = 1'b0;
      end
    end
    last_ga = ga;
    last_gm = gm;
    #1;
  endtask

  task automatic reset_dut();
    reset = 1'b1; alu_valid = 1'b0; mem_valid = 1'b0; iss_valid = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    alu_valid = 1'b1; alu_addr = 5'd1; alu_data = 32'h11;
    mem_valid = 1'b1; mem_addr = 5'd2; mem_data = 32'h22;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (alu_ready !== 1'b0 || mem_ready !== 1'b0) begin
        errors++;
        $display("FAIL reset_ready: got alu=%b mem=%b expected 0/0", alu_ready, mem_ready);
      end
      tick();
      checks++;
      if (enc !== 1'b0 || pending !== 32'h0) begin
        errors++;
        $display("FAIL reset_state: got enc=%b pending=%h expected 0/0", enc, pending);
      end
    end
    reset = 1'b0;
    #1;
    checks++;
    if (alu_ready !== 1'b1 || mem_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_first_grant: got alu=%b mem=%b expected 1/0", alu_ready, mem_ready);
    end
    tick();
    alu_valid = 1'b0; mem_valid = 1'b0;
    checks++;
    if (enc !== 1'b1 || addrc !== 5'd1) begin
      errors++;
      $display("FAIL reset_first_write: got enc=%b addrc=%0d expected 1/1", enc, addrc);
    end
  endtask

  task automatic test_single_write();
    alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'hDEADBEEF;
    #1;
    checks++;
    if (alu_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_ready: got %b expected 1", alu_ready);
    end
    tick();
    alu_valid = 1'b0;
    checks++;
    if (enc !== 1'b1 || addrc !== 5'd5 || datac !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL single_write: got enc=%b addrc=%0d datac=%h expected 1/5/deadbeef",
               enc, addrc, datac);
    end
    tick();
    checks++;
    if (enc !== 1'b0 || addrc !== 5'd5 || datac !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL single_idle: got enc=%b addrc=%0d datac=%h expected 0/5/deadbeef",
               enc, addrc, datac);
    end
  endtask

  task automatic test_contention();
    logic [4:0] ea;
    reset_dut();
    alu_valid = 1'b1; alu_addr = 5'd1; alu_data = 32'h11;
    mem_valid = 1'b1; mem_addr = 5'd2; mem_data = 32'h22;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (alu_ready !== (i % 2 == 0) || mem_ready !== (i % 2 == 1)) begin
        errors++;
        $display("FAIL contention_grant[%0d]: got alu=%b mem=%b", i, alu_ready, mem_ready);
      end
      tick();
      ea = (i % 2 == 0) ? 5'd1 : 5'd2;
      checks++;
      if (enc !== 1'b1 || addrc !== ea || datac !== ((i % 2 == 0) ? 32'h11 : 32'h22)) begin
        errors++;
        $display("FAIL contention_write[%0d]: got enc=%b addrc=%0d datac=%h expected addrc=%0d",
                 i, enc, addrc, datac, ea);
      end
    end
    alu_valid = 1'b0; mem_valid = 1'b0;
    tick();
  endtask

  task automatic test_raw();
    iss_valid = 1'b1; iss_rs = 5'd0; iss_rt = 5'd0; iss_rd = 5'd7; iss_we = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL raw_issue_stall: got %b expected 0", stall);
    end
    tick();
    checks++;
    if (pending[7] !== 1'b1) begin
      errors++;
      $display("FAIL raw_set: got pending=%h expected bit7 set", pending);
    end
    iss_rs = 5'd7; iss_rd = 5'd8;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL raw_stall: got %b expected 1", stall);
    end
    tick();
    mem_valid = 1'b1; mem_addr = 5'd7; mem_data = 32'h77;
    #1;
    checks++;
    if (mem_ready !== 1'b1 || stall !== 1'b1) begin
      errors++;
      $display("FAIL raw_wb_grant: got ready=%b stall=%b expected 1/1", mem_ready, stall);
    end
    tick();
    mem_valid = 1'b0;
    #1;
    checks++;
    if (enc !== 1'b1 || addrc !== 5'd7 || pending[7] !== 1'b1 || stall !== 1'b1) begin
      errors++;
      $display("FAIL raw_wb_commit: got enc=%b addrc=%0d p7=%b stall=%b expected 1/7/1/1",
               enc, addrc, pending[7], stall);
    end
    tick();
    #1;
    checks++;
    if (pending[7] !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL raw_release: got p7=%b stall=%b expected 0/0", pending[7], stall);
    end
    tick();
    iss_valid = 1'b0;
    checks++;
    if (pending !== model_pend_vec()) begin
      errors++;
      $display("FAIL raw_accept: got pending=%h expected %h", pending, model_pend_vec());
    end
  endtask

  task automatic test_reg0();
    reset_dut();
    iss_valid = 1'b1; iss_rs = 5'd0; iss_rt = 5'd0; iss_rd = 5'd0; iss_we = 1'b1;
    tick();
    iss_valid = 1'b0;
    checks++;
    if (pending !== 32'h0) begin
      errors++;
      $display("FAIL reg0_pending: got %h expected 0", pending);
    end
    alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'h1234;
    #1;
    checks++;
    if (alu_ready !== 1'b1) begin
      errors++;
      $display("FAIL reg0_ready: got %b expected 1", alu_ready);
    end
    tick();
    alu_valid = 1'b0;
    checks++;
    if (enc !== 1'b0) begin
      errors++;
      $display("FAIL reg0_enc: got %b expected 0", enc);
    end
  endtask

  task automatic test_mid_reset();
    iss_valid = 1'b1; iss_rs = 5'd0; iss_rt = 5'd0; iss_rd = 5'd3; iss_we = 1'b1;
    tick();
    iss_valid = 1'b0;
    checks++;
    if (pending[3] !== 1'b1) begin
      errors++;
      $display("FAIL midrst_set: got pending=%h expected bit3 set", pending);
    end
    mem_valid = 1'b1; mem_addr = 5'd4; mem_data = 32'h44;
    reset = 1'b1;
    #1;
    checks++;
    if (mem_ready !== 1'b0) begin
      errors++;
      $display("FAIL midrst_ready: got %b expected 0", mem_ready);
    end
    tick();
    checks++;
    if (pending !== 32'h0 || enc !== 1'b0) begin
      errors++;
      $display("FAIL midrst_clear: got pending=%h enc=%b expected 0/0", pending, enc);
    end
    reset = 1'b0; mem_valid = 1'b0;
    tick();
    checks++;
    if (enc !== 1'b0 || pending !== 32'h0) begin
      errors++;
      $display("FAIL midrst_after: got enc=%b pending=%h expected 0/0", enc, pending);
    end
  endtask

  task automatic test_random();
    reset_dut();
    last_ga = 1'b1; last_gm = 1'b1;
    for (int n = 0; n < 400; n++) begin
      if (!alu_valid || last_ga) begin
        alu_valid = ($urandom % 3) != 0;
        alu_addr  = 5'($urandom_range(0, 7));
        alu_data  = $urandom;
      end
      if (!mem_valid || last_gm) begin
        mem_valid = ($urandom % 3) != 0;
        mem_addr  = 5'($urandom_range(0, 7));
        mem_data  = $urandom;
      end
      iss_valid = ($urandom % 2) != 0;
      iss_rs    = 5'($urandom_range(0, 7));
      iss_rt    = 5'($urandom_range(0, 7));
      iss_rd    = 5'($urandom_range(0, 7));
      iss_we    = ($urandom % 4) != 0;
      reset     = ($urandom % 60) == 0;
      #1;
      checks++;
      if (alu_ready !== exp_alu_rdy() || mem_ready !== exp_mem_rdy() || stall !== exp_stall()) begin
        errors++;
        $display("FAIL rand_comb[%0d]: got alu=%b mem=%b stall=%b expected %b/%b/%b", n,
                 alu_ready, mem_ready, stall, exp_alu_rdy(), exp_mem_rdy(), exp_stall());
      end
      tick();
      checks++;
      if (enc !== m_enc || addrc !== m_addrc || datac !== m_datac || pending !== model_pend_vec()) begin
        errors++;
        $display("FAIL rand_state[%0d]: got enc=%b addrc=%0d datac=%h pending=%h expected %b/%0d/%h/%h",
                 n, enc, addrc, datac, pending, m_enc, m_addrc, m_datac, model_pend_vec());
      end
    end
    reset = 1'b0; alu_valid = 1'b0; mem_valid = 1'b0; iss_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
    mem_valid = 1'b0; mem_addr = '0; mem_data = '0;
    iss_valid = 1'b0; iss_rs = '0; iss_rt = '0; iss_rd = '0; iss_we = 1'b0;
    for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
    m_fav_mem = 1'b0; m_enc = 1'b0; m_addrc = '0; m_datac = '0;
    last_ga = 1'b0; last_gm = 1'b0;

    test_reset();
    test_single_write();
    test_contention();
    test_raw();
    test_reg0();
    test_mid_reset();
    test_random();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
